// File: rtl/arduino_hit_receiver_if.sv
// arduino_hit_receiver_if: valid/ready hit handshake between the receiver and game control
interface arduino_hit_receiver_if;
  logic       oHit_valid;
  logic [3:0] oBox_address;
  logic       iHit_ready;
  modport master(output oHit_valid, output oBox_address, input iHit_ready);
  modport slave(input oHit_valid, input oBox_address, output iHit_ready);
endinterface

// File: rtl/arduino_hit_receiver.sv
// arduino_hit_receiver: synchronises, debounces and acknowledges Arduino hit strobes, presenting one box code per strobe
module arduino_hit_receiver #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    iArd_code,
  input  logic                          iArd_strobe,
  output logic                          oArd_ack,
  input  logic                          iEnable,
  arduino_hit_receiver_if.master        hit,
  output logic [7:0]                    oErr_count
);
  typedef enum logic [2:0] {IDLE, SETTLE, PRESENT, ACK, STUCK} state_t;
  localparam logic [CNT_W-1:0] DEB_LD = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state, nxt;
  logic [3:0] code_m, s_code, code_q, code_d;
  logic strobe_m, s_strobe, err_inc, ack_d, valid_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {code_m, strobe_m, s_code, s_strobe} <= '0;
      state <= IDLE;
      cnt <= '0;
      code_q <= '0;
      oArd_ack <= 1'b0;
      hit.oHit_valid <= 1'b0;
      oErr_count <= '0;
    end else begin
      {code_m, strobe_m} <= {iArd_code, iArd_strobe};
      {s_code, s_strobe} <= {code_m, strobe_m};
      state <= nxt;
      cnt <= cnt_d;
      code_q <= code_d;
      oArd_ack <= ack_d;
      hit.oHit_valid <= valid_d;
      oErr_count <= oErr_count + 8'(err_inc && oErr_count != 8'hff);
    end
  // The timeout load happens when debounce completes, so ACK always starts from a full window
  always_comb begin
    nxt = state;
    cnt_d = cnt;
    code_d = code_q;
    err_inc = 1'b0;
    case (state)
      IDLE:
        if (s_strobe && |s_code) begin
          nxt = SETTLE;
          code_d = s_code;
          cnt_d = DEB_LD;
        end else if (s_strobe) begin
          nxt = STUCK;
          err_inc = 1'b1;
        end
      SETTLE:
        if (!s_strobe || s_code != code_q) nxt = IDLE;
        else if (cnt != '0) cnt_d = cnt - 1'b1;
        else begin
          nxt = iEnable ? PRESENT : ACK;
          cnt_d = TMO_LD;
        end
      PRESENT: nxt = (hit.iHit_ready || !iEnable) ? ACK : PRESENT;
      ACK:
        if (!s_strobe) nxt = IDLE;
        else if (cnt == '0) begin
          nxt = STUCK;
          err_inc = 1'b1;
        end else cnt_d = cnt - 1'b1;
      STUCK: nxt = s_strobe ? STUCK : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    ack_d = nxt == ACK;
    valid_d = nxt == PRESENT;
  end
  assign hit.oBox_address = code_q;
endmodule

// File: tb/tb_arduino_hit_receiver.sv
// tb_arduino_hit_receiver: directed scenarios for the Arduino hit receiver with small debounce/timeout windows
module tb_arduino_hit_receiver;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] code = '0;
  logic strobe = 1'b0, en = 1'b1, ack;
  logic [7:0] errs;
  int n_pass = 0, n_tot = 0;
  arduino_hit_receiver_if hif();
  arduino_hit_receiver #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(32), .CNT_W(20)) dut (
    .clk(clk), .reset(reset), .iArd_code(code), .iArd_strobe(strobe), .oArd_ack(ack),
    .iEnable(en), .hit(hif.master), .oErr_count(errs)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic release_strobe();
    strobe = 1'b0;
    code = '0;
    tick(3);
  endtask
  task automatic test_reset();
    hif.iHit_ready = 1'b0;
    tick(2);
    n_tot++; if (hif.oHit_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", hif.oHit_valid); else n_pass++;
    n_tot++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack); else n_pass++;
    n_tot++; if (errs !== 8'd0) $display("FAIL reset_err: got %0d want 0", errs); else n_pass++;
    n_tot++; if (hif.oBox_address !== 4'd0) $display("FAIL reset_addr: got %h want 0", hif.oBox_address); else n_pass++;
    reset = 1'b1;
    tick(2);
  endtask
  task automatic test_basic();
    en = 1'b1;
    code = 4'h5;
    strobe = 1'b1;
    tick(6);
    n_tot++; if (hif.oHit_valid !== 1'b0) $display("FAIL basic_early: got %b want 0", hif.oHit_valid); else n_pass++;
    tick(1);
    n_tot++; if (hif.oHit_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", hif.oHit_valid); else n_pass++;
    n_tot++; if (hif.oBox_address !== 4'h5) $display("FAIL basic_addr: got %h want 5", hif.oBox_address); else n_pass++;
    n_tot++; if (ack !== 1'b0) $display("FAIL basic_noack: got %b want 0", ack); else n_pass++;
    hif.iHit_ready = 1'b1;
    tick(1);
    hif.iHit_ready = 1'b0;
    n_tot++; if ({hif.oHit_valid, ack} !== 2'b01) $display("FAIL basic_handshake: got valid/ack %b want 01", {hif.oHit_valid, ack}); else n_pass++;
    strobe = 1'b0;
    code = '0;
    tick(2);
    n_tot++; if (ack !== 1'b1) $display("FAIL basic_ack_hold: got %b want 1", ack); else n_pass++;
    tick(1);
    n_tot++; if (ack !== 1'b0) $display("FAIL basic_ack_drop: got %b want 0", ack); else n_pass++;
    n_tot++; if (errs !== 8'd0) $display("FAIL basic_err: got %0d want 0", errs); else n_pass++;
  endtask
  task automatic test_glitch();
    code = 4'h3;
    strobe = 1'b1;
    tick(3);
    code = 4'h7;
    tick(7);
    n_tot++; if ({hif.oHit_valid, ack} !== 2'b00) $display("FAIL glitch_quiet: got valid/ack %b want 00", {hif.oHit_valid, ack}); else n_pass++;
    tick(1);
    n_tot++; if (hif.oHit_valid !== 1'b1) $display("FAIL glitch_valid: got %b want 1", hif.oHit_valid); else n_pass++;
    n_tot++; if (hif.oBox_address !== 4'h7) $display("FAIL glitch_addr: got %h want 7", hif.oBox_address); else n_pass++;
    n_tot++; if (errs !== 8'd0) $display("FAIL glitch_err: got %0d want 0", errs); else n_pass++;
    hif.iHit_ready = 1'b1;
    tick(1);
    hif.iHit_ready = 1'b0;
    release_strobe();
  endtask
  task automatic test_disabled();
    en = 1'b0;
    code = 4'h9;
    strobe = 1'b1;
    tick(6);
    n_tot++; if (ack !== 1'b0) $display("FAIL dis_early_ack: got %b want 0", ack); else n_pass++;
    tick(1);
    n_tot++; if (ack !== 1'b1) $display("FAIL dis_ack: got %b want 1", ack); else n_pass++;
    tick(5);
    n_tot++; if ({hif.oHit_valid, ack} !== 2'b01) $display("FAIL dis_hold: got valid/ack %b want 01", {hif.oHit_valid, ack}); else n_pass++;
    release_strobe();
    n_tot++; if ({hif.oHit_valid, ack} !== 2'b00) $display("FAIL dis_idle: got valid/ack %b want 00", {hif.oHit_valid, ack}); else n_pass++;
    en = 1'b1;
  endtask
  task automatic test_backpressure();
    code = 4'hA;
    strobe = 1'b1;
    tick(7);
    n_tot++; if (hif.oHit_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", hif.oHit_valid); else n_pass++;
    tick(10);
    code = 4'h3;
    tick(10);
    n_tot++; if (hif.oHit_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", hif.oHit_valid); else n_pass++;
    n_tot++; if (hif.oBox_address !== 4'hA) $display("FAIL bp_hold_addr: got %h want a", hif.oBox_address); else n_pass++;
    n_tot++; if (ack !== 1'b0) $display("FAIL bp_noack: got %b want 0", ack); else n_pass++;
    en = 1'b0;
    tick(1);
    n_tot++; if ({hif.oHit_valid, ack} !== 2'b01) $display("FAIL bp_abort: got valid/ack %b want 01", {hif.oHit_valid, ack}); else n_pass++;
    release_strobe();
    en = 1'b1;
    n_tot++; if (errs !== 8'd0) $display("FAIL bp_err: got %0d want 0", errs); else n_pass++;
  endtask
  task automatic test_errors();
    code = 4'h0;
    strobe = 1'b1;
    tick(3);
    n_tot++; if ({errs, ack} !== {8'd1, 1'b0}) $display("FAIL err_zero: got err %0d ack %b want 1 0", errs, ack); else n_pass++;
    tick(5);
    n_tot++; if (errs !== 8'd1) $display("FAIL err_stuck_once: got %0d want 1", errs); else n_pass++;
    release_strobe();
    code = 4'h6;
    strobe = 1'b1;
    tick(7);
    hif.iHit_ready = 1'b1;
    tick(1);
    hif.iHit_ready = 1'b0;
    tick(31);
    n_tot++; if ({errs, ack} !== {8'd1, 1'b1}) $display("FAIL err_tmo_before: got err %0d ack %b want 1 1", errs, ack); else n_pass++;
    tick(1);
    n_tot++; if ({errs, ack} !== {8'd2, 1'b0}) $display("FAIL err_tmo: got err %0d ack %b want 2 0", errs, ack); else n_pass++;
    tick(8);
    n_tot++; if ({errs, ack} !== {8'd2, 1'b0}) $display("FAIL err_stuck_hold: got err %0d ack %b want 2 0", errs, ack); else n_pass++;
    release_strobe();
    for (int i = 0; i < 253; i++) begin
      strobe = 1'b1;
      tick(3);
      release_strobe();
    end
    n_tot++; if (errs !== 8'd255) $display("FAIL err_reach_max: got %0d want 255", errs); else n_pass++;
    for (int i = 0; i < 47; i++) begin
      strobe = 1'b1;
      tick(3);
      release_strobe();
    end
    n_tot++; if (errs !== 8'd255) $display("FAIL err_saturate: got %0d want 255", errs); else n_pass++;
  endtask
  task automatic test_reset_mid();
    code = 4'hC;
    strobe = 1'b1;
    tick(7);
    n_tot++; if (hif.oHit_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", hif.oHit_valid); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_tot++; if ({hif.oHit_valid, ack, errs} !== 10'd0) $display("FAIL rst_async: got valid %b ack %b err %0d want 0 0 0", hif.oHit_valid, ack, errs); else n_pass++;
    @(negedge clk) reset = 1'b1;
    tick(6);
    n_tot++; if (hif.oHit_valid !== 1'b0) $display("FAIL rst_redebounce: got %b want 0", hif.oHit_valid); else n_pass++;
    tick(1);
    n_tot++; if (hif.oHit_valid !== 1'b1) $display("FAIL rst_revalid: got %b want 1", hif.oHit_valid); else n_pass++;
    n_tot++; if (hif.oBox_address !== 4'hC) $display("FAIL rst_addr: got %h want c", hif.oBox_address); else n_pass++;
    hif.iHit_ready = 1'b1;
    tick(1);
    hif.iHit_ready = 1'b0;
    release_strobe();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_disabled();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/arduino_hit_receiver.md
Name: arduino_hit_receiver

Overview:
- FPGA-side receiving end of the Arduino→FPGA hit link. Produces the 4-bit box_address that the game control FSM consumes.
- Synchronises the Arduino's parallel code and strobe, debounces them, and presents one clean hit per strobe to control over a valid/ready handshake.
- Acknowledges each strobe back to the Arduino so the Arduino can release its lines and send the next hit.
- Hits arriving outside an active game are acknowledged and discarded.

Parameters:
DEBOUNCE_CYCLES, 50000, cycles code+strobe must be stable before acceptance (1 ms at 50 MHz); minimum 1
TIMEOUT_CYCLES, 500000, max cycles to wait for strobe release after ack before declaring a protocol error
CNT_W, 20, width of the shared debounce/timeout counter; must hold max(DEBOUNCE_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-low reset (0 = reset)
iArd_code  input  4  Arduino box code, asynchronous to clk; 0 = no box
iArd_strobe  input  1  Arduino "code valid" level, asynchronous to clk
oArd_ack  output  1  acknowledge to Arduino, registered
iEnable  input  1  from control: 1 = game active, hits are forwarded
oHit_valid  output  1  hit available to control
oBox_address  output  4  hit box code; valid while oHit_valid = 1
iHit_ready  input  1  control consumes the hit
oErr_count  output  8  protocol error count, saturating

Behaviour:
Synchronisation and reset:
- iArd_code and iArd_strobe each pass through a 2-flop synchroniser; the FSM sees only the synchronised copies (s_code, s_strobe).
- Reset (async, active-low): state IDLE; sync flops, counter and captured code = 0; oArd_ack = 0, oHit_valid = 0, oBox_address = 0, oErr_count = 0.
- Reset mid-operation drops oArd_ack and oHit_valid immediately and discards any pending hit.

States: IDLE, SETTLE, PRESENT, ACK, STUCK.
- IDLE: ack = 0, valid = 0.
  - If s_strobe = 1 and s_code != 0: capture s_code, load counter = DEBOUNCE_CYCLES-1, go to SETTLE.
  - If s_strobe = 1 and s_code = 0: protocol error; increment oErr_count and go to STUCK.
- SETTLE: each cycle, if s_strobe = 0 or s_code != captured code, the event is a glitch; return to IDLE with no error and no ack. Otherwise:
  - If counter != 0: decrement counter.
  - If counter = 0 and iEnable = 1: go to PRESENT.
  - If counter = 0 and iEnable = 0: go to ACK; the hit is silently dropped.
- PRESENT: oHit_valid = 1, oBox_address = captured code, both held stable until the handshake completes.
  - Handshake completes on any cycle with oHit_valid and iHit_ready both 1. Next cycle: valid = 0, go to ACK, load counter = TIMEOUT_CYCLES-1.
  - If iEnable falls while in PRESENT: drop valid, go to ACK with no handshake.
  - Changes on the strobe/code inputs are ignored in PRESENT.
- ACK: oArd_ack = 1.
  - If s_strobe = 0: ack = 0, go to IDLE.
  - Else if counter = 0: increment oErr_count, ack = 0, go to STUCK.
  - Else: decrement counter.
- STUCK: ack = 0, valid = 0. Wait for s_strobe = 0, then go to IDLE. No new hit is accepted until the strobe has been low for at least one synchronised sample.

Timing and width rules:
- Latency: if the clk edge N is the first to sample stable code and strobe, oHit_valid rises after edge N+2+DEBOUNCE_CYCLES.
- Throughput: at most one hit per strobe high period.
- oBox_address keeps its last value after valid falls. Only its value while valid = 1 is defined to control.
- oErr_count increments by 1 per error event and saturates at 255 (no wrap).
- A simultaneous iEnable fall and iHit_ready in the same PRESENT cycle counts as a completed handshake.

Test Plan (DEBOUNCE_CYCLES = 4, TIMEOUT_CYCLES = 32):
1. Basic hit: reset released, iEnable = 1, drive code = 4'b0101 and strobe = 1 held → oHit_valid = 1 and oBox_address = 5 exactly 6 edges after the first sampling edge. With iHit_ready = 1 for one cycle → valid falls and oArd_ack = 1. Drop strobe → ack falls 2-3 cycles later; oErr_count = 0.
2. Glitch rejection: strobe = 1 with code = 3 for 3 cycles, then code = 7 → no valid, no ack; continues to debounce on 7 and presents 7 only after 4 stable cycles.
3. Disabled game: iEnable = 0, code = 9, strobe held → valid never rises, ack rises after debounce, IDLE after strobe drop.
4. Backpressure and abort: valid up with iHit_ready = 0 for 20 cycles → valid and oBox_address held constant. Then drop iEnable → valid = 0 next cycle and ack = 1.
5. Protocol errors: strobe = 1 with code = 0 → oErr_count = 1 and no ack. Strobe held 40 cycles after an acked hit → ack falls after 32 cycles and oErr_count = 2. Force 300 errors → oErr_count = 255.
6. Reset mid-PRESENT with valid = 1: assert reset asynchronously between edges → oHit_valid, oArd_ack and oErr_count go to 0 immediately; after release with strobe still high, a fresh debounce occurs before valid rises again.
